ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter ENABLE_M, default 0, meaning 1 decodes RV32M (R-type, funct7=0000001) as ula_op 11.
REQ-002 Parameter CNT_W, default 16, meaning width of the saturating load-use stall counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instr_id  input  32  instruction held in IF/ID.
REQ-006 valid_id  input  1  instr_id is a real instruction; 0 decodes as bubble.
REQ-007 stall_ext  input  1  external freeze (e.g. memory wait).
REQ-008 flush  input  1  branch/jump redirect; kill the instruction in ID.
REQ-009 jump_id, branch_id, jalr_id  output  1 each  combinational ID-stage decode, forced 0 when valid_id=0.
REQ-010 illegal_id  output  1  valid_id=1 and opcode not in the decode table.
REQ-011 stall_if  output  1  hold PC and IF/ID this cycle.
REQ-012 ex_a_sel  output  2  ALU A: 00 rs1, 01 PC, 10 zero.
REQ-013 ex_b_imm, ex_ula_op, ex_rd, ex_mem_rd  output  1/2/5/1  registered ID/EX fields.
REQ-014 mem_rd, mem_wr, mem_rd_addr  output  1/1/5  registered EX/MEM fields.
REQ-015 wb_reg_wr, wb_sel, wb_rd  output  1/2/5  registered MEM/WB fields; wb_sel 00 ALU, 01 memory, 10 PC+4.
REQ-016 stall_cnt  output  CNT_W  number of load-use bubbles inserted.

Function
REQ-017 Decode SHALL follow: R: reg_wr, ula_op 10, a_sel 00. I-ALU: reg_wr, b_imm, ula_op 10. Load: mem_rd, reg_wr, b_imm, wb_sel 01. Store: mem_wr, b_imm, no reg_wr, no mem_rd. Branch: branch, ula_op 01, no reg_wr. LUI: a_sel 10, b_imm, reg_wr. AUIPC: a_sel 01, b_imm, reg_wr. JAL: jump, a_sel 01, b_imm, reg_wr, wb_sel 10. JALR: jump, jalr, a_sel 00, b_imm, reg_wr, wb_sel 10; all others ula_op 00.
REQ-018 rd fields SHALL carry instr_id[11:7]; reg_wr SHALL be forced 0 when rd=0.
REQ-019 Illegal opcode, valid_id=0, or ENABLE_M=0 with funct7=0000001 on R-type SHALL produce an all-zero bundle (bubble); illegal_id asserts for the opcode case only.
REQ-020 Uses-rs1: R, I-ALU, load, store, branch, JALR; uses-rs2: R, store, branch.
REQ-021 Load-use hazard = ex_mem_rd=1, ex_rd!=0, and ex_rd matches a used rs1 (instr_id[19:15]) or rs2 (instr_id[24:20]).
REQ-022 Priority per cycle: stall_ext > flush > hazard > normal.
REQ-023 stall_ext=1: all stage registers hold, stall_if=1, stall_cnt holds; flush/hazard are not consumed (requester holds flush).
REQ-024 flush=1 (no stall_ext): ID/EX loads bubble, EX/MEM and MEM/WB advance, stall_if=0, no count.
REQ-025 hazard (no stall_ext, no flush): ID/EX loads bubble, later stages advance, stall_if=1, stall_cnt+1 saturating at 2^CNT_W-1.
REQ-026 Normal: ID/EX loads decoded bundle, EX/MEM loads ID/EX mem+wb fields, MEM/WB loads EX/MEM wb fields; latency ID->EX 1, ->MEM 2, ->WB 3 cycles.
REQ-027 A stalled instruction SHALL re-decode next cycle; a single load SHALL cause at most one bubble.

Reset
REQ-028 rst=1 SHALL clear every stage register and stall_cnt to 0 at the next edge, overriding stall_ext/flush; registered outputs read 0 (bubble) the cycle after.
REQ-029 stall_if during reset SHALL be 0; reset mid-stall discards the pending hazard.

Structure
REQ-030 Shared package SHALL hold opcode constants, ula_op, a_sel and wb_sel encodings, and the control-bundle typedef.
REQ-031 Combinational decode SHALL be a sub-module ctrl_decode; ctrl_pipe holds stage registers, hazard logic and counter.

Verification
REQ-032 Reset then ADD x3,x1,x2 valid -> cycle+1 ex_ula_op=10, a_sel=00; cycle+3 wb_reg_wr=1, wb_rd=3, wb_sel=00.
REQ-033 LW x5,0(x1) then ADD x6,x5,x2 -> one cycle stall_if=1, one bubble in EX, stall_cnt=1, ADD reaches EX one cycle late.
REQ-034 LW x5 then ADD x6,x0,x0 (rs2=x0) and LW x0 then ADD x6,x0,x0 -> no stall, stall_cnt=0.
REQ-035 flush=1 with hazard present -> stall_if=0, EX bubble, stall_cnt unchanged; stall_ext=1 for 3 cycles -> all outputs frozen.
REQ-036 Opcode 0000000 valid -> illegal_id=1, bubble; LUI vs AUIPC -> a_sel 10 vs 01; MUL with ENABLE_M=1 -> ula_op 11, with 0 -> bubble.
REQ-037 CNT_W=2 with 5 load-use pairs -> stall_cnt saturates at 3; rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings and control-bundle types for the ID/EX/MEM/WB control pipeline.
package ctrl_pipe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ULA_ADD   = 2'b00,
    ULA_BR    = 2'b01,
    ULA_FUNCT = 2'b10,
    ULA_M     = 2'b11
  } ula_op_e;

  typedef enum logic [1:0] {
    A_RS1  = 2'b00,
    A_PC   = 2'b01,
    A_ZERO = 2'b10
  } a_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       b_imm;
    logic       jump;
    logic       branch;
    logic       jalr;
    ula_op_e    ula_op;
    a_sel_e     a_sel;
    wb_sel_e    wb_sel;
    logic [4:0] rd;
  } ctrl_t;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    wb_sel_e    wb_sel;
    logic [4:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic       reg_wr;
    wb_sel_e    wb_sel;
    logic [4:0] rd;
  } mem_wb_t;

  localparam ctrl_t   CTRL_BUBBLE   = '0;
  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  // True when a load destination feeds a source register the instruction actually reads.
  function automatic logic rs_hit(input logic [4:0] rd, input logic [4:0] rs, input logic used);
    return used && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Combinational ID-stage decode: opcode/funct7 to control bundle plus source-use flags.
module ctrl_decode
  import ctrl_pipe_pkg::*;
#(
  parameter int ENABLE_M = 0
) (
  input  logic [6:0] opcode_i,
  input  logic [4:0] rd_i,
  input  logic [6:0] funct7_i,
  input  logic       valid_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o,
  output logic       use_rs1_o,
  output logic       use_rs2_o
);

  ctrl_t c;
  logic  legal;
  logic  m_blocked;
  logic  use1;
  logic  use2;

  always_comb begin
    c         = CTRL_BUBBLE;
    legal     = 1'b1;
    m_blocked = 1'b0;
    use1      = 1'b0;
    use2      = 1'b0;
    case (opcode_i)
      OP_R: begin
        c.reg_wr = 1'b1;
        c.a_sel  = A_RS1;
        use1     = 1'b1;
        use2     = 1'b1;
        if (funct7_i == F7_MULDIV) begin
          if (ENABLE_M != 0) c.ula_op = ULA_M;
          else               m_blocked = 1'b1;
        end else begin
          c.ula_op = ULA_FUNCT;
        end
      end
      OP_IALU: begin
        c.reg_wr = 1'b1;
        c.b_imm  = 1'b1;
        c.ula_op = ULA_FUNCT;
        use1     = 1'b1;
      end
      OP_LOAD: begin
        c.mem_rd = 1'b1;
        c.reg_wr = 1'b1;
        c.b_imm  = 1'b1;
        c.wb_sel = WB_MEM;
        use1     = 1'b1;
      end
      OP_STORE: begin
        c.mem_wr = 1'b1;
        c.b_imm  = 1'b1;
        use1     = 1'b1;
        use2     = 1'b1;
      end
      OP_BRANCH: begin
        c.branch = 1'b1;
        c.ula_op = ULA_BR;
        use1     = 1'b1;
        use2     = 1'b1;
      end
      OP_LUI: begin
        c.a_sel  = A_ZERO;
        c.b_imm  = 1'b1;
        c.reg_wr = 1'b1;
      end
      OP_AUIPC: begin
        c.a_sel  = A_PC;
        c.b_imm  = 1'b1;
        c.reg_wr = 1'b1;
      end
      OP_JAL: begin
        c.jump   = 1'b1;
        c.a_sel  = A_PC;
        c.b_imm  = 1'b1;
        c.reg_wr = 1'b1;
        c.wb_sel = WB_PC4;
      end
      OP_JALR: begin
        c.jump   = 1'b1;
        c.jalr   = 1'b1;
        c.a_sel  = A_RS1;
        c.b_imm  = 1'b1;
        c.reg_wr = 1'b1;
        c.wb_sel = WB_PC4;
        use1     = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    c.rd = rd_i;
    if (rd_i == 5'd0) c.reg_wr = 1'b0;

    // Anything that is not a real, permitted instruction collapses to a full bubble.
    if (!valid_i || !legal || m_blocked) begin
      c    = CTRL_BUBBLE;
      use1 = 1'b0;
      use2 = 1'b0;
    end

    ctrl_o    = c;
    illegal_o = valid_i && !legal;
    use_rs1_o = use1;
    use_rs2_o = use2;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: ID/EX, EX/MEM, MEM/WB control registers, load-use hazard and bubble counter.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_id,
  input  logic             valid_id,
  input  logic             stall_ext,
  input  logic             flush,
  output logic             jump_id,
  output logic             branch_id,
  output logic             jalr_id,
  output logic             illegal_id,
  output logic             stall_if,
  output logic [1:0]       ex_a_sel,
  output logic             ex_b_imm,
  output logic [1:0]       ex_ula_op,
  output logic [4:0]       ex_rd,
  output logic             ex_mem_rd,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [4:0]       mem_rd_addr,
  output logic             wb_reg_wr,
  output logic [1:0]       wb_sel,
  output logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_t      id_ctrl;
  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  logic       unused_funct3;

  ctrl_t      id_ex_q,  id_ex_d;
  ex_mem_t    ex_mem_q, ex_mem_d;
  mem_wb_t    mem_wb_q, mem_wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign unused_funct3 = ^instr_id[14:12];

  ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .opcode_i  (instr_id[6:0]),
    .rd_i      (instr_id[11:7]),
    .funct7_i  (instr_id[31:25]),
    .valid_i   (valid_id),
    .ctrl_o    (id_ctrl),
    .illegal_o (illegal_id),
    .use_rs1_o (use_rs1),
    .use_rs2_o (use_rs2)
  );

  assign hazard = id_ex_q.mem_rd &&
                  (rs_hit(id_ex_q.rd, instr_id[19:15], use_rs1) ||
                   rs_hit(id_ex_q.rd, instr_id[24:20], use_rs2));

  always_comb begin
    id_ex_d  = id_ex_q;
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    cnt_d    = cnt_q;
    stall_if = 1'b0;
    if (rst) begin
      stall_if = 1'b0;
    end else if (stall_ext) begin
      stall_if = 1'b1;
    end else begin
      ex_mem_d.mem_rd = id_ex_q.mem_rd;
      ex_mem_d.mem_wr = id_ex_q.mem_wr;
      ex_mem_d.reg_wr = id_ex_q.reg_wr;
      ex_mem_d.wb_sel = id_ex_q.wb_sel;
      ex_mem_d.rd     = id_ex_q.rd;
      mem_wb_d.reg_wr = ex_mem_q.reg_wr;
      mem_wb_d.wb_sel = ex_mem_q.wb_sel;
      mem_wb_d.rd     = ex_mem_q.rd;
      if (flush) begin
        id_ex_d = CTRL_BUBBLE;
      end else if (hazard) begin
        // The bubble lets the load reach MEM; the consumer re-decodes next cycle.
        id_ex_d  = CTRL_BUBBLE;
        stall_if = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end else begin
        id_ex_d = id_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q  <= CTRL_BUBBLE;
      ex_mem_q <= EX_MEM_BUBBLE;
      mem_wb_q <= MEM_WB_BUBBLE;
      cnt_q    <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign jump_id     = id_ctrl.jump;
  assign branch_id   = id_ctrl.branch;
  assign jalr_id     = id_ctrl.jalr;

  assign ex_a_sel    = id_ex_q.a_sel;
  assign ex_b_imm    = id_ex_q.b_imm;
  assign ex_ula_op   = id_ex_q.ula_op;
  assign ex_rd       = id_ex_q.rd;
  assign ex_mem_rd   = id_ex_q.mem_rd;

  assign mem_rd      = ex_mem_q.mem_rd;
  assign mem_wr      = ex_mem_q.mem_wr;
  assign mem_rd_addr = ex_mem_q.rd;

  assign wb_reg_wr   = mem_wb_q.reg_wr;
  assign wb_sel      = mem_wb_q.wb_sel;
  assign wb_rd       = mem_wb_q.rd;

  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: stimulus queues expected values per cycle, a monitor compares.
module tb_ctrl_pipe;

  localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  localparam int S_STALL_IF = 0,  S_ILLEGAL = 1,  S_EX_ULA = 2,   S_EX_ASEL = 3;
  localparam int S_EX_BIMM  = 4,  S_EX_RD   = 5,  S_EX_MEMRD = 6, S_MEM_RD = 7;
  localparam int S_MEM_WR   = 8,  S_MEM_ADDR = 9, S_WB_REGWR = 10, S_WB_SEL = 11;
  localparam int S_WB_RD    = 12, S_CNT     = 13, S_JUMP = 14,    S_BRANCH = 15;
  localparam int S_JALR     = 16, S_D0_ULA  = 17, S_D0_EXRD = 18, S_D0_CNT = 19;
  localparam int S_ALL      = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_id;
  logic        valid_id, stall_ext, flush;

  logic jump_id, branch_id, jalr_id, illegal_id, stall_if;
  logic [1:0] ex_a_sel, ex_ula_op, wb_sel;
  logic ex_b_imm, ex_mem_rd, mem_rd, mem_wr, wb_reg_wr;
  logic [4:0] ex_rd, mem_rd_addr, wb_rd;
  logic [1:0] stall_cnt;

  logic d0_jump_id, d0_branch_id, d0_jalr_id, d0_illegal_id, d0_stall_if;
  logic [1:0] d0_ex_a_sel, d0_ex_ula_op, d0_wb_sel;
  logic d0_ex_b_imm, d0_ex_mem_rd, d0_mem_rd, d0_mem_wr, d0_wb_reg_wr;
  logic [4:0] d0_ex_rd, d0_mem_rd_addr, d0_wb_rd;
  logic [15:0] d0_stall_cnt;

  ctrl_pipe #(.ENABLE_M(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .instr_id(instr_id), .valid_id(valid_id),
    .stall_ext(stall_ext), .flush(flush),
    .jump_id(jump_id), .branch_id(branch_id), .jalr_id(jalr_id),
    .illegal_id(illegal_id), .stall_if(stall_if),
    .ex_a_sel(ex_a_sel), .ex_b_imm(ex_b_imm), .ex_ula_op(ex_ula_op),
    .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rd_addr(mem_rd_addr),
    .wb_reg_wr(wb_reg_wr), .wb_sel(wb_sel), .wb_rd(wb_rd),
    .stall_cnt(stall_cnt)
  );

  ctrl_pipe dut0 (
    .clk(clk), .rst(rst), .instr_id(instr_id), .valid_id(valid_id),
    .stall_ext(stall_ext), .flush(flush),
    .jump_id(d0_jump_id), .branch_id(d0_branch_id), .jalr_id(d0_jalr_id),
    .illegal_id(d0_illegal_id), .stall_if(d0_stall_if),
    .ex_a_sel(d0_ex_a_sel), .ex_b_imm(d0_ex_b_imm), .ex_ula_op(d0_ex_ula_op),
    .ex_rd(d0_ex_rd), .ex_mem_rd(d0_ex_mem_rd),
    .mem_rd(d0_mem_rd), .mem_wr(d0_mem_wr), .mem_rd_addr(d0_mem_rd_addr),
    .wb_reg_wr(d0_wb_reg_wr), .wb_sel(d0_wb_sel), .wb_rd(d0_wb_rd),
    .stall_cnt(d0_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sig;
    string       nm;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(input int s);
    case (s)
      S_STALL_IF: return 32'(stall_if);
      S_ILLEGAL:  return 32'(illegal_id);
      S_EX_ULA:   return 32'(ex_ula_op);
      S_EX_ASEL:  return 32'(ex_a_sel);
      S_EX_BIMM:  return 32'(ex_b_imm);
      S_EX_RD:    return 32'(ex_rd);
      S_EX_MEMRD: return 32'(ex_mem_rd);
      S_MEM_RD:   return 32'(mem_rd);
      S_MEM_WR:   return 32'(mem_wr);
      S_MEM_ADDR: return 32'(mem_rd_addr);
      S_WB_REGWR: return 32'(wb_reg_wr);
      S_WB_SEL:   return 32'(wb_sel);
      S_WB_RD:    return 32'(wb_rd);
      S_CNT:      return 32'(stall_cnt);
      S_JUMP:     return 32'(jump_id);
      S_BRANCH:   return 32'(branch_id);
      S_JALR:     return 32'(jalr_id);
      S_D0_ULA:   return 32'(d0_ex_ula_op);
      S_D0_EXRD:  return 32'(d0_ex_rd);
      S_D0_CNT:   return 32'(d0_stall_cnt);
      S_ALL:      return {4'b0, ex_a_sel, ex_b_imm, ex_ula_op, ex_rd, ex_mem_rd, mem_rd,
                          mem_wr, mem_rd_addr, wb_reg_wr, wb_sel, wb_rd, stall_cnt};
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation scheduled for the current cycle, away from the edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] act;
        act = get_sig(sb[i].sig);
        n_tests++;
        if (act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%0h expected=%0h", sb[i].nm, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic ex(input int dly, input int sig, input string nm, input logic [31:0] v);
    sb_t e;
    e.cyc = cyc + dly;
    e.sig = sig;
    e.nm  = nm;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    instr_id = ins;
    valid_id = v;
  endtask

  task automatic bubble(input int n);
    drive(32'h0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, OP_R};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b010, rd, OP_LOAD};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall_ext = 1'b1; flush = 1'b1;
    drive(lw(5'd5, 5'd1), 1'b1);
    tick();
    ex(0, S_STALL_IF, "rst_stall_if", 0);
    ex(0, S_ALL, "rst_regs", 0);
    ex(0, S_D0_CNT, "rst_d0_cnt", 0);
    tick();
    rst = 1'b0; stall_ext = 1'b0; flush = 1'b0;

    // ADD x3,x1,x2 through the pipe
    drive(r_type(7'd0, 5'd2, 5'd1, 5'd3), 1'b1);
    ex(0, S_ILLEGAL, "add_illegal", 0);
    ex(1, S_EX_ULA, "add_ex_ula", 2);
    ex(1, S_EX_ASEL, "add_ex_asel", 0);
    ex(1, S_EX_RD, "add_ex_rd", 3);
    ex(2, S_MEM_ADDR, "add_mem_rd", 3);
    ex(3, S_WB_REGWR, "add_wb_regwr", 1);
    ex(3, S_WB_RD, "add_wb_rd", 3);
    ex(3, S_WB_SEL, "add_wb_sel", 0);
    tick();
    bubble(4);

    // load-use: LW x5 then ADD x6,x5,x2
    drive(lw(5'd5, 5'd1), 1'b1);
    ex(0, S_STALL_IF, "lu_lw_stall", 0);
    ex(1, S_EX_MEMRD, "lu_ex_memrd", 1);
    ex(1, S_EX_RD, "lu_ex_rd", 5);
    tick();
    drive(r_type(7'd0, 5'd2, 5'd5, 5'd6), 1'b1);
    ex(0, S_STALL_IF, "lu_stall", 1);
    ex(1, S_EX_RD, "lu_bubble_rd", 0);
    ex(1, S_EX_ULA, "lu_bubble_ula", 0);
    ex(1, S_CNT, "lu_cnt", 1);
    ex(1, S_D0_CNT, "lu_d0_cnt", 1);
    ex(1, S_MEM_RD, "lu_mem_rd", 1);
    ex(1, S_MEM_ADDR, "lu_mem_addr", 5);
    tick();
    ex(0, S_STALL_IF, "lu_restart", 0);
    ex(1, S_EX_RD, "lu_add_late_rd", 6);
    ex(1, S_EX_ULA, "lu_add_late_ula", 2);
    ex(1, S_WB_SEL, "lu_lw_wb_sel", 1);
    ex(1, S_WB_RD, "lu_lw_wb_rd", 5);
    tick();
    bubble(4);

    // no-hazard cases: x0 sources, load to x0; then a store rs2 hazard
    drive(lw(5'd5, 5'd1), 1'b1);
    tick();
    drive(r_type(7'd0, 5'd0, 5'd0, 5'd6), 1'b1);
    ex(0, S_STALL_IF, "nh_rs_x0", 0);
    ex(1, S_EX_RD, "nh_rs_x0_rd", 6);
    ex(1, S_CNT, "nh_cnt", 1);
    tick();
    drive(lw(5'd0, 5'd1), 1'b1);
    ex(1, S_EX_MEMRD, "nh_lw0_memrd", 1);
    ex(1, S_EX_RD, "nh_lw0_rd", 0);
    tick();
    drive(r_type(7'd0, 5'd0, 5'd0, 5'd6), 1'b1);
    ex(0, S_STALL_IF, "nh_lw0_stall", 0);
    ex(1, S_CNT, "nh_lw0_cnt", 1);
    tick();
    drive(lw(5'd7, 5'd1), 1'b1);
    tick();
    drive({7'd0, 5'd7, 5'd1, 3'b010, 5'd0, OP_STORE}, 1'b1);
    ex(0, S_STALL_IF, "sw_rs2_stall", 1);
    ex(1, S_CNT, "sw_rs2_cnt", 2);
    tick();
    ex(0, S_STALL_IF, "sw_restart", 0);
    ex(1, S_EX_BIMM, "sw_ex_bimm", 1);
    ex(1, S_EX_MEMRD, "sw_ex_memrd", 0);
    ex(2, S_MEM_WR, "sw_mem_wr", 1);
    tick();
    bubble(4);

    // flush beats hazard
    drive(lw(5'd5, 5'd1), 1'b1);
    tick();
    drive(r_type(7'd0, 5'd2, 5'd5, 5'd6), 1'b1);
    flush = 1'b1;
    ex(0, S_STALL_IF, "fl_stall_if", 0);
    ex(1, S_EX_RD, "fl_bubble_rd", 0);
    ex(1, S_EX_ULA, "fl_bubble_ula", 0);
    ex(1, S_CNT, "fl_cnt", 2);
    ex(1, S_MEM_RD, "fl_mem_rd", 1);
    tick();
    flush = 1'b0;
    bubble(4);

    // external freeze for three cycles with a hazard pending
    drive(r_type(7'd0, 5'd2, 5'd1, 5'd3), 1'b1);
    tick();
    drive(lw(5'd5, 5'd1), 1'b1);
    tick();
    drive(r_type(7'd0, 5'd2, 5'd5, 5'd6), 1'b1);
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex(0, S_STALL_IF, "fz_stall_if", 1);
      ex(1, S_EX_RD, "fz_ex_rd", 5);
      ex(1, S_EX_MEMRD, "fz_ex_memrd", 1);
      ex(1, S_MEM_ADDR, "fz_mem_addr", 3);
      ex(1, S_WB_RD, "fz_wb_rd", 0);
      ex(1, S_CNT, "fz_cnt", 2);
      tick();
    end
    stall_ext = 1'b0;
    ex(0, S_STALL_IF, "fz_rel_stall", 1);
    ex(1, S_EX_RD, "fz_rel_bubble", 0);
    ex(1, S_MEM_ADDR, "fz_rel_mem", 5);
    ex(1, S_WB_RD, "fz_rel_wb_rd", 3);
    ex(1, S_WB_REGWR, "fz_rel_wb_wr", 1);
    ex(1, S_CNT, "fz_rel_cnt", 3);
    tick();
    ex(1, S_EX_RD, "fz_add_rd", 6);
    ex(1, S_WB_RD, "fz_lw_wb_rd", 5);
    ex(1, S_WB_SEL, "fz_lw_wb_sel", 1);
    tick();
    bubble(4);

    // decode table corners
    drive(32'h0000_0F80, 1'b1);
    ex(0, S_ILLEGAL, "ill_op0", 1);
    ex(1, S_EX_RD, "ill_bubble_rd", 0);
    ex(1, S_EX_ULA, "ill_bubble_ula", 0);
    tick();
    drive(32'h0000_0F80, 1'b0);
    ex(0, S_ILLEGAL, "ill_invalid", 0);
    tick();
    drive({20'h12345, 5'd4, OP_LUI}, 1'b1);
    ex(1, S_EX_ASEL, "lui_asel", 2);
    ex(1, S_EX_BIMM, "lui_bimm", 1);
    ex(1, S_EX_RD, "lui_rd", 4);
    ex(3, S_WB_REGWR, "lui_wb_wr", 1);
    ex(3, S_WB_RD, "lui_wb_rd", 4);
    tick();
    drive({20'h12345, 5'd9, OP_AUIPC}, 1'b1);
    ex(1, S_EX_ASEL, "auipc_asel", 1);
    ex(1, S_EX_RD, "auipc_rd", 9);
    tick();
    drive(r_type(7'b0000001, 5'd2, 5'd1, 5'd7), 1'b1);
    ex(0, S_ILLEGAL, "mul_illegal", 0);
    ex(1, S_EX_ULA, "mul_m1_ula", 3);
    ex(1, S_EX_RD, "mul_m1_rd", 7);
    ex(1, S_D0_ULA, "mul_m0_ula", 0);
    ex(1, S_D0_EXRD, "mul_m0_rd", 0);
    tick();
    drive({20'h00000, 5'd1, OP_JAL}, 1'b1);
    ex(0, S_JUMP, "jal_jump", 1);
    ex(0, S_JALR, "jal_jalr", 0);
    ex(1, S_EX_ASEL, "jal_asel", 1);
    ex(3, S_WB_SEL, "jal_wb_sel", 2);
    ex(3, S_WB_RD, "jal_wb_rd", 1);
    tick();
    drive({12'h000, 5'd1, 3'b000, 5'd1, OP_JALR}, 1'b1);
    ex(0, S_JUMP, "jalr_jump", 1);
    ex(0, S_JALR, "jalr_jalr", 1);
    ex(1, S_EX_ASEL, "jalr_asel", 0);
    ex(1, S_EX_BIMM, "jalr_bimm", 1);
    tick();
    drive({7'd0, 5'd2, 5'd1, 3'b000, 5'd0, OP_BR}, 1'b1);
    ex(0, S_BRANCH, "beq_branch", 1);
    ex(0, S_JUMP, "beq_jump", 0);
    ex(1, S_EX_ULA, "beq_ula", 1);
    ex(3, S_WB_REGWR, "beq_wb_wr", 0);
    tick();
    drive({20'h00000, 5'd1, OP_JAL}, 1'b0);
    ex(0, S_JUMP, "jal_invalid", 0);
    tick();
    bubble(4);

    // counter saturation with CNT_W=2 against the 16-bit default
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex(0, S_ALL, "sat_rst_regs", 0);
    for (int k = 1; k <= 5; k++) begin
      drive(lw(5'd5, 5'd1), 1'b1);
      tick();
      drive(r_type(7'd0, 5'd2, 5'd5, 5'd6), 1'b1);
      ex(0, S_STALL_IF, "sat_stall", 1);
      ex(1, S_CNT, "sat_cnt", (k > 3) ? 3 : k);
      ex(1, S_D0_CNT, "sat_d0_cnt", k);
      tick();
      tick();
    end
    bubble(2);

    // reset in the middle of a load-use stall
    drive(lw(5'd5, 5'd1), 1'b1);
    tick();
    drive(r_type(7'd0, 5'd2, 5'd5, 5'd6), 1'b1);
    rst = 1'b1;
    ex(0, S_STALL_IF, "mid_rst_stall", 0);
    ex(1, S_ALL, "mid_rst_regs", 0);
    tick();
    rst = 1'b0;
    ex(0, S_STALL_IF, "mid_rst_no_hazard", 0);
    ex(1, S_EX_RD, "mid_rst_add_rd", 6);
    tick();
    bubble(5);

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain got=%0d expected=0 pending", sb.size());
      n_fail += sb.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
